ad7606_seq_ctrl: RTL and testbench
==================================

AD7606_SEQ_CTRL -- requirements
Module: ad7606_seq_ctrl

Interface
REQ-001 SHALL have parameter NCH, default 8: channels read per frame (1..8).
REQ-002 SHALL have parameter CONV_LO_CYC, default 2: clk cycles adc_convst_o is held low.
REQ-003 SHALL have parameter RD_LO_CYC, default 3: clk cycles adc_rd_n_o is held low per channel.
REQ-004 SHALL have parameter RD_HI_CYC, default 2: clk cycles adc_rd_n_o is held high between channels.
REQ-005 SHALL have parameter RST_CYC, default 4: clk cycles of the adc_reset_o pulse after reset release.
REQ-006 SHALL have parameter TMO_CYC, default 40000: BUSY timeout in clk cycles.
REQ-007 SHALL have port clk_i  input  1  system clock; all logic on the rising edge.
REQ-008 SHALL have port reset_i  input  1  reset, asynchronous, active-high.
REQ-009 SHALL have port start_i  input  1  one-cycle acquisition request.
REQ-010 SHALL have port os_i  input  3  oversampling code, latched on accepted start.
REQ-011 SHALL have port adc_db_i  input  16  ADC parallel data bus.
REQ-012 SHALL have port adc_busy_i  input  1  ADC BUSY, asynchronous to clk_i.
REQ-013 SHALL have port adc_frstdata_i  input  1  ADC FRSTDATA.
REQ-014 SHALL have ports adc_convst_o, adc_cs_n_o, adc_rd_n_o, adc_reset_o  output  1 each  ADC control pins.
REQ-015 SHALL have port adc_os_o  output  3  registered oversampling code to ADC.
REQ-016 SHALL have ports sample_o  output  16, sample_ch_o  output  3, sample_valid_o  output  1  per-channel result.
REQ-017 SHALL have ports ready_o, frame_done_o, err_o  output  1 each  idle flag, frame-complete pulse, sticky error.

Function
REQ-018 SHALL synchronise adc_busy_i through two flops; all BUSY decisions use the synchronised value.
REQ-019 SHALL implement states INIT, IDLE, CONV, WAIT_HI, WAIT_LO, RD_LO, RD_HI, DONE, ERR.
REQ-020 INIT: adc_reset_o=1 for RST_CYC cycles, then IDLE.
REQ-021 IDLE: ready_o=1; start_i=1 latches os_i into adc_os_o, clears channel counter, goes to CONV; start_i outside IDLE SHALL be ignored.
REQ-022 CONV: adc_convst_o=0 for CONV_LO_CYC cycles, then 1, go to WAIT_HI.
REQ-023 WAIT_HI: on sync BUSY=1 go to WAIT_LO; WAIT_LO: on sync BUSY=0 assert adc_cs_n_o=0, go to RD_LO.
REQ-024 One timeout counter SHALL run from CONV exit through WAIT_LO; reaching TMO_CYC goes to ERR.
REQ-025 RD_LO: adc_rd_n_o=0 for RD_LO_CYC cycles; on the last cycle adc_db_i is captured into sample_o, sample_ch_o=channel count, sample_valid_o pulses 1 cycle after capture.
REQ-026 On channel 0 capture, adc_frstdata_i=0 SHALL go to ERR (no sample_valid_o); on channels 1..NCH-1, frstdata=1 SHALL go to ERR.
REQ-027 RD_HI: adc_rd_n_o=1 for RD_HI_CYC cycles, then RD_LO for next channel; after channel NCH-1 go directly to DONE.
REQ-028 DONE: adc_cs_n_o=1, frame_done_o=1 for one cycle, return to IDLE.
REQ-029 ERR: err_o=1 (sticky), all ADC strobes inactive, go to INIT (re-reset ADC); err_o clears only on next accepted start_i.
REQ-030 Channel counter SHALL be 3 bits, reset per frame, never wrap within a frame.
REQ-031 adc_cs_n_o SHALL stay low continuously from first RD_LO to DONE; adc_rd_n_o SHALL never be low while adc_cs_n_o is high.

Reset
REQ-032 While reset_i=1: state INIT with counters 0, adc_convst_o=1, adc_cs_n_o=1, adc_rd_n_o=1, adc_reset_o=1, adc_os_o=0, sample_o=0, sample_ch_o=0, sample_valid_o=0, frame_done_o=0, ready_o=0, err_o=0.
REQ-033 Reset mid-frame SHALL abort immediately with the values above; no partial frame_done_o.

Verification
REQ-034 Reset release -> adc_reset_o high exactly 4 cycles, ready_o=1 next cycle.
REQ-035 start_i, os_i=000, ADC model BUSY 4 us -> convst low 2 cycles, 8 sample_valid_o pulses ch 0..7 matching bus values, one frame_done_o, adc_os_o=000.
REQ-036 start_i with os_i=011 then os_i changed mid-frame -> adc_os_o stays 011 for whole frame.
REQ-037 BUSY held low forever after CONV -> err_o=1 after 40000 cycles, adc_reset_o pulse, ready_o=1, no frame_done_o.
REQ-038 FRSTDATA forced 0 on channel 0 -> err_o=1, zero sample_valid_o.
REQ-039 start_i pulsed during RD_LO and reset_i asserted on channel 4 -> first ignored; reset forces CS/RD high same cycle.

Source files
------------

// File: rtl/ad7606_seq_ctrl_if.sv
// AD7606 parallel-interface pin bundle.
// master: the sequencer driving the ADC control pins.
// slave:  the ADC (or a model of it) driving data, BUSY and FRSTDATA.
interface ad7606_seq_ctrl_if;
    logic [15:0] adc_db_i;
    logic        adc_busy_i;
    logic        adc_frstdata_i;
    logic        adc_convst_o;
    logic        adc_cs_n_o;
    logic        adc_rd_n_o;
    logic        adc_reset_o;
    logic [2:0]  adc_os_o;

    modport master (
        input  adc_db_i,
        input  adc_busy_i,
        input  adc_frstdata_i,
        output adc_convst_o,
        output adc_cs_n_o,
        output adc_rd_n_o,
        output adc_reset_o,
        output adc_os_o
    );

    modport slave (
        output adc_db_i,
        output adc_busy_i,
        output adc_frstdata_i,
        input  adc_convst_o,
        input  adc_cs_n_o,
        input  adc_rd_n_o,
        input  adc_reset_o,
        input  adc_os_o
    );
endinterface

// File: rtl/ad7606_seq_ctrl.sv
// AD7606 acquisition sequencer: resets the ADC, issues CONVST on request,
// waits for BUSY (with timeout), then reads NCH channels over the parallel
// bus while checking FRSTDATA alignment. All ADC strobes are registered.
module ad7606_seq_ctrl #(
    parameter int NCH         = 8,
    parameter int CONV_LO_CYC = 2,
    parameter int RD_LO_CYC   = 3,
    parameter int RD_HI_CYC   = 2,
    parameter int RST_CYC     = 4,
    parameter int TMO_CYC     = 40000
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     start_i,
    input  logic [2:0]               os_i,
    ad7606_seq_ctrl_if.master        adc,
    output logic [15:0]              sample_o,
    output logic [2:0]               sample_ch_o,
    output logic                     sample_valid_o,
    output logic                     ready_o,
    output logic                     frame_done_o,
    output logic                     err_o
);

    localparam int TW = $clog2(TMO_CYC + 1);

    typedef enum logic [3:0] {
        INIT, IDLE, CONV, WAIT_HI, WAIT_LO, RD_LO, RD_HI, DONE, ERR
    } state_t;

    state_t        state;
    logic [7:0]    cnt;
    logic [TW-1:0] tmo;
    logic [2:0]    ch;
    logic          cap_pend;
    logic          busy_meta;
    logic          busy_sync;
    logic          frst_bad;

    // FRSTDATA must be high only while channel 0 is on the bus
    always_comb begin
        frst_bad = (ch == 3'd0) ? ~adc.adc_frstdata_i : adc.adc_frstdata_i;
    end

    // Two-flop synchroniser for the asynchronous BUSY pin
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            busy_meta <= 1'b0;
            busy_sync <= 1'b0;
        end else begin
            busy_meta <= adc.adc_busy_i;
            busy_sync <= busy_meta;
        end
    end

    // Sequencer FSM with registered ADC strobes and status outputs
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state            <= INIT;
            cnt              <= '0;
            tmo              <= '0;
            ch               <= '0;
            cap_pend         <= 1'b0;
            adc.adc_convst_o <= 1'b1;
            adc.adc_cs_n_o   <= 1'b1;
            adc.adc_rd_n_o   <= 1'b1;
            adc.adc_reset_o  <= 1'b1;
            adc.adc_os_o     <= '0;
            sample_o         <= '0;
            sample_ch_o      <= '0;
            sample_valid_o   <= 1'b0;
            frame_done_o     <= 1'b0;
            ready_o          <= 1'b0;
            err_o            <= 1'b0;
        end else begin
            frame_done_o   <= 1'b0;
            sample_valid_o <= cap_pend;
            cap_pend       <= 1'b0;
            case (state)
                INIT: begin
                    if (cnt == 8'(RST_CYC - 1)) begin
                        adc.adc_reset_o <= 1'b0;
                        ready_o         <= 1'b1;
                        cnt             <= '0;
                        state           <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                IDLE: begin
                    if (start_i) begin
                        adc.adc_os_o     <= os_i;
                        adc.adc_convst_o <= 1'b0;
                        ch               <= '0;
                        cnt              <= '0;
                        err_o            <= 1'b0;
                        ready_o          <= 1'b0;
                        state            <= CONV;
                    end
                end
                CONV: begin
                    if (cnt == 8'(CONV_LO_CYC - 1)) begin
                        adc.adc_convst_o <= 1'b1;
                        tmo              <= '0;
                        state            <= WAIT_HI;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                WAIT_HI: begin
                    // timeout spans both wait states without restarting
                    if (tmo == TW'(TMO_CYC - 1)) begin
                        err_o <= 1'b1;
                        state <= ERR;
                    end else begin
                        tmo <= tmo + 1'b1;
                        if (busy_sync) state <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (tmo == TW'(TMO_CYC - 1)) begin
                        err_o <= 1'b1;
                        state <= ERR;
                    end else if (!busy_sync) begin
                        adc.adc_cs_n_o <= 1'b0;
                        adc.adc_rd_n_o <= 1'b0;
                        cnt            <= '0;
                        state          <= RD_LO;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                RD_LO: begin
                    if (cnt == 8'(RD_LO_CYC - 1)) begin
                        adc.adc_rd_n_o <= 1'b1;
                        cnt            <= '0;
                        if (frst_bad) begin
                            adc.adc_cs_n_o <= 1'b1;
                            err_o          <= 1'b1;
                            state          <= ERR;
                        end else begin
                            sample_o    <= adc.adc_db_i;
                            sample_ch_o <= ch;
                            cap_pend    <= 1'b1;
                            state       <= (ch == 3'(NCH - 1)) ? DONE : RD_HI;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RD_HI: begin
                    if (cnt == 8'(RD_HI_CYC - 1)) begin
                        adc.adc_rd_n_o <= 1'b0;
                        ch             <= ch + 3'd1;
                        cnt            <= '0;
                        state          <= RD_LO;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    adc.adc_cs_n_o <= 1'b1;
                    frame_done_o   <= 1'b1;
                    ready_o        <= 1'b1;
                    state          <= IDLE;
                end
                ERR: begin
                    adc.adc_convst_o <= 1'b1;
                    adc.adc_cs_n_o   <= 1'b1;
                    adc.adc_rd_n_o   <= 1'b1;
                    adc.adc_reset_o  <= 1'b1;
                    cnt              <= '0;
                    state            <= INIT;
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_ad7606_seq_ctrl.sv
// Directed bench for ad7606_seq_ctrl with a behavioural AD7606 model
// (BUSY ~4 us after CONVST, incrementing data per channel, FRSTDATA on ch 0).
module tb_ad7606_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        start_i;
    logic [2:0]  os_i;
    logic [15:0] sample_o;
    logic [2:0]  sample_ch_o;
    logic        sample_valid_o;
    logic        ready_o;
    logic        frame_done_o;
    logic        err_o;

    ad7606_seq_ctrl_if adc ();

    ad7606_seq_ctrl #(
        .NCH         (8),
        .CONV_LO_CYC (2),
        .RD_LO_CYC   (3),
        .RD_HI_CYC   (2),
        .RST_CYC     (4),
        .TMO_CYC     (40000)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .start_i        (start_i),
        .os_i           (os_i),
        .adc            (adc),
        .sample_o       (sample_o),
        .sample_ch_o    (sample_ch_o),
        .sample_valid_o (sample_valid_o),
        .ready_o        (ready_o),
        .frame_done_o   (frame_done_o),
        .err_o          (err_o)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ADC model controls
    bit          model_en  = 1'b0;
    bit          bad_frst0 = 1'b0;
    logic [15:0] base      = '0;
    int          idx       = 0;

    // BUSY: rises 20 ns after CONVST rising edge, held for 4 us
    initial begin
        adc.adc_busy_i = 1'b0;
        forever begin
            @(posedge adc.adc_convst_o);
            if (model_en) begin
                #20;
                adc.adc_busy_i = 1'b1;
                #4000;
                adc.adc_busy_i = 1'b0;
            end
        end
    end

    // Data bus: next channel word on each RD falling edge, index restarts when CS rises
    initial begin
        adc.adc_db_i       = '0;
        adc.adc_frstdata_i = 1'b0;
        forever begin
            @(negedge adc.adc_rd_n_o or posedge adc.adc_cs_n_o);
            if (adc.adc_rd_n_o == 1'b0) begin
                adc.adc_db_i       = base + 16'(idx);
                adc.adc_frstdata_i = (idx == 0) && !bad_frst0;
                idx++;
            end else begin
                idx = 0;
            end
        end
    end

    // Observation log, sampled on the falling edge
    int          n_valid   = 0;
    int          n_done    = 0;
    int          n_conv_lo = 0;
    int          n_viol    = 0;
    logic [15:0] dat_log [64];
    logic [2:0]  ch_log  [64];

    initial begin
        forever begin
            @(negedge clk);
            if (sample_valid_o === 1'b1 && n_valid < 64) begin
                dat_log[n_valid] = sample_o;
                ch_log[n_valid]  = sample_ch_o;
                n_valid++;
            end
            if (frame_done_o === 1'b1) n_done++;
            if (adc.adc_convst_o === 1'b0) n_conv_lo++;
            if (adc.adc_rd_n_o === 1'b0 && adc.adc_cs_n_o === 1'b1) n_viol++;
        end
    end

    task automatic pulse_start(input logic [2:0] os);
        @(negedge clk);
        os_i    = os;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    int k, j, v0, d0, c0;

    initial begin
        reset_i = 1'b1;
        start_i = 1'b0;
        os_i    = 3'b000;

        // reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_convst", 32'(adc.adc_convst_o), 32'd1);
        check("rst_cs_n",   32'(adc.adc_cs_n_o),   32'd1);
        check("rst_rd_n",   32'(adc.adc_rd_n_o),   32'd1);
        check("rst_adcrst", 32'(adc.adc_reset_o),  32'd1);
        check("rst_os",     32'(adc.adc_os_o),     32'd0);
        check("rst_sample", 32'(sample_o),         32'd0);
        check("rst_ch",     32'(sample_ch_o),      32'd0);
        check("rst_valid",  32'(sample_valid_o),   32'd0);
        check("rst_done",   32'(frame_done_o),     32'd0);
        check("rst_ready",  32'(ready_o),          32'd0);
        check("rst_err",    32'(err_o),            32'd0);

        // ADC reset pulse after release
        @(posedge clk);
        #1 reset_i = 1'b0;
        k = 0;
        @(negedge clk);
        while (adc.adc_reset_o === 1'b1 && k < 20) begin
            k++;
            @(negedge clk);
        end
        check("init_rst_len", 32'(k),       32'd4);
        check("init_ready",   32'(ready_o), 32'd1);

        // frame with os=000
        base = 16'h1230; model_en = 1'b1;
        v0 = n_valid; d0 = n_done; c0 = n_conv_lo;
        pulse_start(3'b000);
        check("f1_ready_low", 32'(ready_o), 32'd0);
        k = 0;
        while (n_done == d0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("f1_no_timeout", 32'(k < 3000), 32'd1);
        @(negedge clk);
        check("f1_convst_lo", 32'(n_conv_lo - c0), 32'd2);
        check("f1_nvalid",    32'(n_valid - v0),   32'd8);
        check("f1_ndone",     32'(n_done - d0),    32'd1);
        for (int i = 0; i < 8; i++) begin
            check("f1_ch",   32'(ch_log[v0 + i]),  32'(i));
            check("f1_data", 32'(dat_log[v0 + i]), 32'(16'h1230 + 16'(i)));
        end
        check("f1_os",    32'(adc.adc_os_o),   32'd0);
        check("f1_cs_n",  32'(adc.adc_cs_n_o), 32'd1);
        check("f1_err",   32'(err_o),          32'd0);
        check("f1_ready", 32'(ready_o),        32'd1);

        // os latched on start, later os_i changes ignored
        base = 16'h5A00;
        v0 = n_valid; d0 = n_done;
        pulse_start(3'b011);
        repeat (50) @(negedge clk);
        os_i = 3'b101;
        @(negedge clk);
        check("f2_os_wait", 32'(adc.adc_os_o), 32'd3);
        k = 0;
        while (adc.adc_cs_n_o !== 1'b0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("f2_cs_seen", 32'(k < 3000),     32'd1);
        check("f2_os_rd",   32'(adc.adc_os_o), 32'd3);
        k = 0;
        while (n_done == d0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("f2_no_timeout", 32'(k < 3000),        32'd1);
        check("f2_os_done",    32'(adc.adc_os_o),    32'd3);
        @(negedge clk);
        check("f2_nvalid",     32'(n_valid - v0),    32'd8);
        for (int i = 0; i < 8; i++) begin
            check("f2_data", 32'(dat_log[v0 + i]), 32'(16'h5A00 + 16'(i)));
        end
        check("f2_os_idle", 32'(adc.adc_os_o), 32'd3);

        // BUSY never rises: timeout after 40000 cycles
        model_en = 1'b0;
        v0 = n_valid; d0 = n_done;
        pulse_start(3'b000);
        k = 0;
        while (adc.adc_convst_o !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("tmo_convst_up", 32'(k < 10), 32'd1);
        k = 0;
        while (err_o !== 1'b1 && k < 40100) begin
            @(negedge clk);
            k++;
        end
        check("tmo_cycles", 32'(k), 32'd40000);
        j = 0;
        while (adc.adc_reset_o !== 1'b1 && j < 10) begin
            @(negedge clk);
            j++;
        end
        check("tmo_adcrst_seen", 32'(j < 10), 32'd1);
        k = 0;
        while (adc.adc_reset_o === 1'b1 && k < 20) begin
            k++;
            @(negedge clk);
        end
        check("tmo_adcrst_len", 32'(k),            32'd4);
        check("tmo_ready",      32'(ready_o),      32'd1);
        check("tmo_err_sticky", 32'(err_o),        32'd1);
        check("tmo_ndone",      32'(n_done - d0),  32'd0);
        check("tmo_nvalid",     32'(n_valid - v0), 32'd0);
        repeat (5) @(negedge clk);
        check("tmo_err_hold",   32'(err_o),        32'd1);

        // FRSTDATA low on channel 0
        model_en = 1'b1; bad_frst0 = 1'b1;
        v0 = n_valid; d0 = n_done;
        pulse_start(3'b000);
        check("frst_err_clr", 32'(err_o), 32'd0);
        k = 0;
        while (err_o !== 1'b1 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("frst_err", 32'(err_o), 32'd1);
        repeat (3) @(negedge clk);
        check("frst_nvalid", 32'(n_valid - v0), 32'd0);
        check("frst_ndone",  32'(n_done - d0),  32'd0);
        k = 0;
        while (ready_o !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("frst_ready", 32'(ready_o), 32'd1);
        bad_frst0 = 1'b0;

        // start during RD_LO ignored, reset on channel 4
        base = 16'h7700;
        v0 = n_valid; d0 = n_done;
        pulse_start(3'b010);
        k = 0;
        while (adc.adc_cs_n_o !== 1'b0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("mid_cs_seen", 32'(k < 3000),        32'd1);
        check("mid_rd_low",  32'(adc.adc_rd_n_o),  32'd0);
        os_i    = 3'b111;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check("mid_os_kept", 32'(adc.adc_os_o), 32'd2);
        k = 0;
        while ((n_valid - v0) < 4 && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("mid_4_valid", 32'(n_valid - v0), 32'd4);
        k = 0;
        while (adc.adc_rd_n_o !== 1'b0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("mid_ch4_rd",  32'(adc.adc_rd_n_o), 32'd0);
        check("mid_ch4_cs",  32'(adc.adc_cs_n_o), 32'd0);
        reset_i = 1'b1;
        #1;
        check("mid_rst_cs_n",   32'(adc.adc_cs_n_o),   32'd1);
        check("mid_rst_rd_n",   32'(adc.adc_rd_n_o),   32'd1);
        check("mid_rst_convst", 32'(adc.adc_convst_o), 32'd1);
        check("mid_rst_adcrst", 32'(adc.adc_reset_o),  32'd1);
        check("mid_rst_sample", 32'(sample_o),         32'd0);
        check("mid_rst_ready",  32'(ready_o),          32'd0);
        for (int i = 0; i < 4; i++) begin
            check("mid_data", 32'(dat_log[v0 + i]), 32'(16'h7700 + 16'(i)));
        end
        @(negedge clk);
        check("mid_ndone", 32'(n_done - d0), 32'd0);
        @(posedge clk);
        #1 reset_i = 1'b0;
        k = 0;
        while (ready_o !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("mid_ready",   32'(ready_o),       32'd1);
        check("mid_ndone2",  32'(n_done - d0),   32'd0);
        check("mid_nvalid",  32'(n_valid - v0),  32'd4);
        check("rd_without_cs", 32'(n_viol),      32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
